// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller: die codes, controller states,
// face width and the die-to-sides lookup.
package dice_pkg;

  localparam int FACE_W = 5;

  typedef enum logic [2:0] {
    D4  = 3'd0,
    D6  = 3'd1,
    D8  = 3'd2,
    D10 = 3'd3,
    D12 = 3'd4,
    D20 = 3'd5
  } die_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic logic [FACE_W-1:0] sides(input die_e d);
    case (d)
      D4:      return 5'd4;
      D6:      return 5'd6;
      D8:      return 5'd8;
      D10:     return 5'd10;
      D12:     return 5'd12;
      default: return 5'd20;
    endcase
  endfunction

endpackage

// File: rtl/roll_controller_btn_edge.sv
// btn_edge: registers a bank of level buttons and reports rising edges
// (input high while the registered copy is low). The first cycle after
// reset release is masked so a button held through reset does not count
// as a fresh press.
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] btn_q;
  logic         settle_q;

  // Registered copy of the buttons plus the post-reset mask flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q    <= '0;
      settle_q <= 1'b1;
    end else begin
      btn_q    <= btn_i;
      settle_q <= 1'b0;
    end
  end

  assign rise_o = settle_q ? '0 : (btn_i & ~btn_q);

endmodule

// File: rtl/roll_controller.sv
// roll_controller: die selection and timed roll sequencer for a dice game.
// A free-running face counter cycles 1..sides every clock; a roll lasts
// ROLL_CYCLES clocks and captures the counter (or the maximum face when
// test_sw is high) at its last cycle.
// Build option ROLL_ANIMATION_EN: when defined, result shows the live face
// counter while rolling; otherwise result holds its previous value.
module roll_controller
  import dice_pkg::*;
#(
  parameter int ROLL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        die_btn,
  input  logic              roll_btn,
  input  logic              test_sw,
  output logic [2:0]        die_sel,
  output logic [FACE_W-1:0] result,
  output logic              result_valid,
  output logic              busy
);

  localparam logic [7:0] CNT_LOAD = 8'(ROLL_CYCLES - 1);

  logic [5:0]        die_rise;
  logic              roll_rise;
  logic              die_ok;
  die_e              die_idx;
  logic              face_reset;

  state_e            state_q, state_d;
  die_e              die_q, die_d;
  logic [FACE_W-1:0] face_q, face_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [FACE_W-1:0] result_q, result_d;
  logic              rv_q, rv_d;

  btn_edge #(.W(6)) u_die_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (die_btn),
    .rise_o (die_rise)
  );

  btn_edge #(.W(1)) u_roll_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (roll_btn),
    .rise_o (roll_rise)
  );

  // Decode a die-select edge: valid only when exactly one button rose
  always_comb begin
    die_ok  = (die_rise != 6'd0) && ((die_rise & (die_rise - 6'd1)) == 6'd0);
    die_idx = D20;
    for (int i = 0; i < 6; i++) begin
      if (die_rise[i]) die_idx = die_e'(3'(i));
    end
  end

  // Next-state logic; a roll edge takes priority over a simultaneous die edge
  always_comb begin
    state_d    = state_q;
    die_d      = die_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    rv_d       = rv_q;
    face_reset = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (roll_rise) begin
          state_d = ROLLING;
          rv_d    = 1'b0;
          cnt_d   = CNT_LOAD;
        end else if (die_ok) begin
          state_d    = IDLE;
          die_d      = die_idx;
          rv_d       = 1'b0;
          face_reset = 1'b1;
        end
      end
      ROLLING: begin
        if (cnt_q == 8'd0) begin
          state_d  = DONE;
          rv_d     = 1'b1;
          result_d = test_sw ? sides(die_q) : face_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Face counter advances every clock and wraps at the selected die's sides
  always_comb begin
    if (face_reset || (face_q >= sides(die_q))) face_d = 5'd1;
    else                                          face_d = face_q + 5'd1;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      die_q    <= D20;
      face_q   <= 5'd1;
      cnt_q    <= 8'd0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      die_q    <= die_d;
      face_q   <= face_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign die_sel      = die_q;
  assign result_valid = rv_q;
  assign busy         = (state_q == ROLLING);
`ifdef ROLL_ANIMATION_EN
  assign result       = (state_q == ROLLING) ? face_q : result_q;
`else
  assign result       = result_q;
`endif

endmodule

// File: tb/tb_roll_controller.sv
// Scoreboard bench for roll_controller: the driver predicts each roll's
// outcome from a cycle-indexed face model and queues it; a monitor pops and
// compares when result_valid rises and checks result while rolling.
module tb_roll_controller;

  localparam int ROLL = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] die_btn = 6'd0;
  logic       roll_btn = 1'b0;
  logic       test_sw = 1'b0;
  logic [2:0] die_sel;
  logic [4:0] result;
  logic       result_valid;
  logic       busy;

  roll_controller #(.ROLL_CYCLES(ROLL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .die_btn      (die_btn),
    .roll_btn     (roll_btn),
    .test_sw      (test_sw),
    .die_sel      (die_sel),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: selected die, and the cycle in which the face was 1
  int m_die = 5;
  int m_c0 = 0;
  bit rolling = 1'b0;

  typedef struct {
    int res;
    int die;
  } exp_t;
  exp_t sb[$];

  function automatic int sides_of(int d);
    int t[6] = '{4, 6, 8, 10, 12, 20};
    return t[d];
  endfunction

  function automatic int face_at(int c);
    return 1 + ((c - m_c0) % sides_of(m_die));
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int bcnt = 0;
  bit prev_rv = 1'b0;
  int held = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      bcnt++;
`ifdef ROLL_ANIMATION_EN
      check("anim_face", result, face_at(cyc));
`else
      check("hold_result", result, held);
`endif
    end else begin
      if (result_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          check("sb_has_entry", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("die_sel_done", die_sel, e.die);
          check("busy_len", bcnt, ROLL);
        end
      end
      bcnt = 0;
      held = result;
    end
    prev_rv = result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_die = 5;
    m_c0 = cyc;
    rolling = 1'b0;
  endtask

  task automatic press_die(logic [5:0] b);
    die_btn = b;
    if (($countones(b) == 1) && !rolling) begin
      for (int i = 0; i < 6; i++) if (b[i]) m_die = i;
      m_c0 = cyc + 1;
    end
    tick();
    die_btn = 6'd0;
    tick();
  endtask

  task automatic do_roll(bit with_die, logic [5:0] db, bit junk);
    int t;
    int n;
    exp_t e;
    t = cyc;
    roll_btn = 1'b1;
    if (with_die) die_btn = db;
    e.die = m_die;
    e.res = test_sw ? sides_of(m_die) : 1 + ((t + ROLL - m_c0) % sides_of(m_die));
    sb.push_back(e);
    rolling = 1'b1;
    tick();
    roll_btn = 1'b0;
    die_btn = 6'd0;
    tick();
    if (junk) begin
      repeat (3) tick();
      roll_btn = 1'b1;
      tick();
      roll_btn = 1'b0;
      tick();
      press_die(6'b000001);
      press_die(6'b100000);
    end
    n = 0;
    while (!result_valid && n < 4 * ROLL) begin
      tick();
      n++;
    end
    if (!result_valid) check("roll_timeout", result_valid, 1);
    rolling = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rb;
    int sel;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_c0 = cyc;
    m_die = 5;
    check("rst_die_sel", die_sel, 5);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    tick();

    // Roll button held through reset release must not start a roll
    roll_btn = 1'b1;
    do_reset();
    repeat (3) tick();
    check("held_btn_busy", busy, 0);
    roll_btn = 1'b0;
    tick();

    // Die select: single edge accepted, double edge ignored
    press_die(6'b000100);
    check("sel_d8", die_sel, 2);
    press_die(6'b000011);
    check("sel_multi_ignored", die_sel, 2);

    // Roll timing with D6
    press_die(6'b000010);
    check("sel_d6", die_sel, 1);
    do_roll(1'b0, 6'd0, 1'b0);

    // Test mode: maximum face
    test_sw = 1'b1;
    press_die(6'b100000);
    do_roll(1'b0, 6'd0, 1'b0);
    press_die(6'b000001);
    do_roll(1'b0, 6'd0, 1'b0);
    test_sw = 1'b0;

    // Inputs during ROLLING are ignored
    press_die(6'b000010);
    do_roll(1'b0, 6'd0, 1'b1);
    check("die_after_junk", die_sel, 1);

    // Die edge coincident with roll edge: roll wins, old die kept
    do_roll(1'b1, 6'b001000, 1'b0);
    check("die_roll_same_cycle", die_sel, 1);

    // Reset mid-roll
    roll_btn = 1'b1;
    rolling = 1'b1;
    tick();
    roll_btn = 1'b0;
    repeat (5) tick();
    do_reset();
    check("midroll_die_sel", die_sel, 5);
    check("midroll_result", result, 0);
    check("midroll_busy", busy, 0);
    check("midroll_valid", result_valid, 0);
    tick();

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      sel = $urandom_range(0, 3);
      rb = 6'($urandom);
      if (sel == 0) begin
        press_die(6'(1 << $urandom_range(0, 5)));
        check("rand_sel", die_sel, m_die);
      end else if (sel == 3) begin
        press_die(rb);
        check("rand_sel_any", die_sel, m_die);
      end else begin
        test_sw = ($urandom_range(0, 4) == 0);
        do_roll($urandom_range(0, 5) == 0, rb, $urandom_range(0, 3) == 0);
        test_sw = 1'b0;
      end
    end

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/roll_controller.md
ROLL_CONTROLLER -- requirements
Module: roll_controller

Interface
REQ-001 SHALL have parameter ROLL_CYCLES, default 16: roll duration in clocks, legal range 2..255.
REQ-002 SHALL have port clk, input, 1: sole clock, all state rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port die_btn, input, 6: level die-select buttons, pre-debounced, bit0..5 = D4,D6,D8,D10,D12,D20.
REQ-005 SHALL have port roll_btn, input, 1: level roll request, pre-debounced.
REQ-006 SHALL have port test_sw, input, 1: test mode, forces maximum face.
REQ-007 SHALL have port die_sel, output, 3: selected die code 0..5, same order as die_btn.
REQ-008 SHALL have port result, output, 5: face value 1..20.
REQ-009 SHALL have port result_valid, output, 1: result holds a completed roll.
REQ-010 SHALL have port busy, output, 1: high while rolling.

Function
REQ-011 SHALL register die_btn and roll_btn once and act only on rising edges (input high, registered copy low).
REQ-012 SHALL use states IDLE, ROLLING, DONE; busy=1 exactly in ROLLING.
REQ-013 SHALL accept a die-select edge only when exactly one die_btn bit rises in that cycle; zero or multiple rising bits change nothing.
REQ-014 SHALL, on an accepted die edge in IDLE or DONE, load die_sel next cycle, reset the face counter to 1, clear result_valid, go to IDLE.
REQ-015 SHALL ignore die edges in ROLLING, and ignore a die edge in the same cycle as an accepted roll edge (roll wins, old die used).
REQ-016 SHALL keep a face counter cycling 1..sides(die_sel), incrementing every clock in every state, wrapping sides->1.
REQ-017 SHALL, on a roll edge in IDLE or DONE, enter ROLLING, clear result_valid, load the cycle counter with ROLL_CYCLES-1.
REQ-018 SHALL decrement the cycle counter each ROLLING clock; in the cycle it reads 0, capture result and go to DONE, so busy is high exactly ROLL_CYCLES clocks.
REQ-019 SHALL capture result = face counter value, or result = sides(die_sel) when test_sw is high in the capture cycle.
REQ-020 SHALL assert result_valid in DONE and hold result constant there until the next roll or die change.
REQ-021 SHALL ignore roll edges during ROLLING (no restart, no extension).
REQ-022 SHALL map sides as D4=4, D6=6, D8=8, D10=10, D12=12, D20=20; result never outside 1..sides.

Reset
REQ-023 SHALL, with rst_n low at a clock edge, including mid-roll, set state IDLE, die_sel=5 (D20), result=0, result_valid=0, busy=0, face counter=1, cycle counter=0, registered button copies=0.
REQ-024 SHALL treat a button held through reset release as not pressed until released and pressed again.

Configuration
REQ-025 SHALL honour macro ROLL_ANIMATION_EN: defined -> result shows the live face counter during ROLLING (result_valid low); undefined -> result holds its previous value during ROLLING, updating only at capture.
REQ-026 SHALL behave identically in both builds outside ROLLING and at capture.

Structure
REQ-027 SHALL take the die code enum (D4..D20), sides lookup function, state enum and face width constant (5) from shared package dice_pkg.
REQ-028 SHALL instantiate one sub-module btn_edge (register plus rising-edge pulse, width parameter) for die_btn and roll_btn.

Verification
REQ-029 SHALL cover reset: drive rst_n low mid-roll for 1 clock -> die_sel=5, result=0, busy=0, result_valid=0 next cycle.
REQ-030 SHALL cover select: pulse die_btn=6'b000100 in IDLE -> die_sel=2; then die_btn=6'b000011 -> die_sel stays 2.
REQ-031 SHALL cover roll timing: die D6, roll_btn edge at cycle T -> busy high T+1..T+16, result_valid high at T+17, result in 1..6 and equal to the face counter model.
REQ-032 SHALL cover test mode: die D20, test_sw=1, roll -> result=20; die D4 -> result=4.
REQ-033 SHALL cover ignored inputs: roll_btn and die_btn edges during ROLLING -> die_sel, busy length, result unchanged.
REQ-034 SHALL cover both ROLL_ANIMATION_EN builds: during ROLLING result steps 1,2,3.. (defined) or stays at prior value (undefined).
